// File: rtl/mips_fetch_pkg.sv
// Shared fetch-side types: FSM state, instruction size and queue entry.
// Imported by pc_fetch_unit and fetch_buffer.
package mips_fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FE_ADDR_W = 32;
  localparam int FE_DATA_W = 32;

  typedef enum logic {
    FETCH,
    WAIT
  } fetch_state_t;

  typedef struct packed {
    logic [FE_ADDR_W-1:0] pc;
    logic [FE_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry fetch queue; head is held in registers so decode
// sees registered INSTR/INSTR_PC.
module fetch_buffer
  import mips_fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);

  entry_t slot1;
  logic   pop_ok;
  logic   push_ok;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push_ok, pop_ok})
        2'b11: begin
          if (full) begin
            head  <= slot1;
            slot1 <= din;
          end else begin
            head <= din;
          end
        end
        2'b10: begin
          if (empty) head <= din;
          else       slot1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= slot1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher with redirect squash and 2-entry queue.
// Optional PC_MISALIGN_TRAP_EN adds sticky MISALIGN_ERR on unaligned redirects.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PC_SRC_SEL,
  input  logic [ADDR_WIDTH-1:0] PC_Branch,
  output logic                  IMEM_REQ,
  output logic [ADDR_WIDTH-1:0] IMEM_ADDR,
  input  logic                  IMEM_GNT,
  input  logic                  IMEM_RVALID,
  input  logic [DATA_WIDTH-1:0] IMEM_RDATA,
  output logic                  INSTR_VALID,
  output logic [DATA_WIDTH-1:0] INSTR,
  output logic [ADDR_WIDTH-1:0] INSTR_PC,
  input  logic                  INSTR_READY,
  output logic [ADDR_WIDTH-1:0] PC_Current
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic                  MISALIGN_ERR
`endif
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [1:0]            infl;
  logic [1:0]            drop;
  logic [1:0]            count;
  logic                  run;
  logic                  err;
  logic                  fire;
  logic                  rv_any;
  logic                  live_rv;
  logic                  dead_rv;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [1:0]            drop_base;
  entry_t                head;
  entry_t                din;

`ifdef PC_MISALIGN_TRAP_EN
  logic bad_tgt;

  assign bad_tgt = PC_SRC_SEL && (PC_Branch[1:0] != 2'b00);
  assign MISALIGN_ERR = err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err <= 1'b0;
    else     err <= err | bad_tgt;
  end
`else
  assign err = 1'b0;
`endif

  // infl counts every granted read still owed a response,
  // including squashed ones; drop counts the squashed subset.
  assign IMEM_REQ = run && !err && (state == FETCH) &&
                    (({1'b0, count} + {1'b0, infl}) < 3'd2);
  assign fire      = IMEM_REQ && IMEM_GNT;
  assign rv_any    = IMEM_RVALID && (infl != 2'd0);
  assign dead_rv   = rv_any && (drop != 2'd0);
  assign live_rv   = rv_any && (drop == 2'd0) && (state == WAIT);
  assign drop_base = drop - {1'b0, dead_rv};

  assign pop  = INSTR_VALID && INSTR_READY;
  assign push = live_rv && !PC_SRC_SEL && !err &&
                (!full || pop);
  assign din  = '{pc: req_pc, instr: IMEM_RDATA};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= FETCH;
      pc     <= RESET_VECTOR;
      req_pc <= RESET_VECTOR;
      infl   <= 2'd0;
      drop   <= 2'd0;
      run    <= 1'b0;
    end else begin
      run  <= 1'b1;
      infl <= infl + {1'b0, fire} - {1'b0, rv_any};
      if (fire) req_pc <= pc;
      if (PC_SRC_SEL) begin
        state <= FETCH;
        pc    <= PC_Branch;
        drop  <= drop_base
               + {1'b0, (state == WAIT) && !live_rv}
               + {1'b0, fire};
      end else begin
        drop <= drop_base;
        if (fire) begin
          state <= WAIT;
          pc    <= pc + STEP;
        end else if (live_rv) begin
          state <= FETCH;
        end
      end
    end
  end

  fetch_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .flush (PC_SRC_SEL),
    .din   (din),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign IMEM_ADDR   = pc;
  assign PC_Current  = pc;
  assign INSTR_VALID = !empty;
  assign INSTR       = head.instr;
  assign INSTR_PC    = head.pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus random traffic
// against a program-order stream model with an in-order memory.
module tb_pc_fetch_unit;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_SRC_SEL = 1'b0;
  logic [31:0] PC_Branch = '0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = '0;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic [31:0] INSTR_PC;
  logic        INSTR_READY = 1'b0;
  logic [31:0] PC_Current;

  logic        w_gnt = 1'b1;
  logic        w_zero = 1'b0;
  logic        w_rdy = 1'b1;
  logic [31:0] w_zero32 = '0;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;
  logic [31:0] w_pcc;

`ifdef PC_MISALIGN_TRAP_EN
  logic MISALIGN_ERR;
  logic w_err;
`endif

  always #5 CLK = ~CLK;

  pc_fetch_unit dut (
    .CLK         (CLK),
    .RST         (RST),
    .PC_SRC_SEL  (PC_SRC_SEL),
    .PC_Branch   (PC_Branch),
    .IMEM_REQ    (IMEM_REQ),
    .IMEM_ADDR   (IMEM_ADDR),
    .IMEM_GNT    (IMEM_GNT),
    .IMEM_RVALID (IMEM_RVALID),
    .IMEM_RDATA  (IMEM_RDATA),
    .INSTR_VALID (INSTR_VALID),
    .INSTR       (INSTR),
    .INSTR_PC    (INSTR_PC),
    .INSTR_READY (INSTR_READY),
    .PC_Current  (PC_Current)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .MISALIGN_ERR (MISALIGN_ERR)
`endif
  );

  pc_fetch_unit #(
    .RESET_VECTOR (32'hFFFF_FFFC)
  ) u_wrap (
    .CLK         (CLK),
    .RST         (RST),
    .PC_SRC_SEL  (w_zero),
    .PC_Branch   (w_zero32),
    .IMEM_REQ    (w_req),
    .IMEM_ADDR   (w_addr),
    .IMEM_GNT    (w_gnt),
    .IMEM_RVALID (w_zero),
    .IMEM_RDATA  (w_zero32),
    .INSTR_VALID (w_valid),
    .INSTR       (w_instr),
    .INSTR_PC    (w_ipc),
    .INSTR_READY (w_rdy),
    .PC_Current  (w_pcc)
`ifdef PC_MISALIGN_TRAP_EN
    ,
    .MISALIGN_ERR (w_err)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          fires = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] exp_fetch = '0;
  logic [31:0] exp_pop = '0;
  bit          p_req, p_gnt, p_redir;
  logic [31:0] p_tgt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  // One clock cycle: compare, drive, then advance the model.
  task automatic step(input bit g, input bit rdy, input bit redir,
                      input logic [31:0] tgt);
    bit    rv;
    bit    fire_now;
    mreq_t e;
    if (!RST) begin
      chk("pc_current", PC_Current, exp_fetch);
      if (IMEM_REQ) begin
        chk("imem_addr", IMEM_ADDR, exp_fetch);
        chk("req_cap", 32'(mq.size() < 2), 32'd1);
      end
      if (INSTR_VALID) begin
        chk("instr_pc", INSTR_PC, exp_pop);
        chk("instr_data", INSTR, memf(INSTR_PC));
      end
      if (p_redir) begin
        chk("flush", 32'(INSTR_VALID), 32'd0);
        if (mq.size() < 2 && (!TRAP || p_tgt[1:0] == 2'b00))
          chk("redir_req", 32'(IMEM_REQ), 32'd1);
      end else if (p_req && !p_gnt) begin
        chk("hold_req", 32'(IMEM_REQ), 32'd1);
      end
    end
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    IMEM_GNT    = g;
    INSTR_READY = rdy;
    PC_SRC_SEL  = redir;
    PC_Branch   = tgt;
    IMEM_RVALID = rv;
    IMEM_RDATA  = rv ? memf(mq[0].addr) : $urandom;
    #1;
    fire_now = IMEM_REQ && g;
    if (rv) void'(mq.pop_front());
    if (fire_now) begin
      e.addr = exp_fetch;
      e.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      mq.push_back(e);
      fires++;
      exp_fetch += 32'd4;
    end
    if (INSTR_VALID && rdy && !redir) begin
      pops++;
      exp_pop += 32'd4;
    end
    if (redir) begin
      exp_fetch = tgt;
      exp_pop   = tgt;
    end
    p_req   = IMEM_REQ;
    p_gnt   = g;
    p_redir = redir;
    p_tgt   = tgt;
    cyc++;
    @(negedge CLK);
  endtask

  task automatic rst_on();
    IMEM_GNT    = 1'b0;
    IMEM_RVALID = 1'b0;
    PC_SRC_SEL  = 1'b0;
    INSTR_READY = 1'b0;
    RST = 1'b1;
    #1;
    mq.delete();
    exp_fetch = '0;
    exp_pop   = '0;
    p_req = 0;
    p_gnt = 0;
    p_redir = 0;
  endtask

  task automatic rst_off();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    repeat (2) @(negedge CLK);
    chk("rst_req", 32'(IMEM_REQ), 32'd0);
    chk("rst_valid", 32'(INSTR_VALID), 32'd0);
    chk("rst_addr", IMEM_ADDR, 32'd0);
    RST = 1'b0;
    step(1'b1, 1'b1, 1'b0, '0);
    chk("post_rst_req", 32'(IMEM_REQ), 32'd1);
    chk("post_rst_addr", IMEM_ADDR, 32'd0);
    chk("wrap_first_req", 32'(w_req), 32'd1);
    chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);

    // stream: one fetch every two cycles
    step(1'b1, 1'b1, 1'b0, '0);
    chk("wrap_second_addr", w_addr, 32'd0);
    chk("wrap_pc", w_pcc, 32'd0);
    step(1'b1, 1'b1, 1'b0, '0);
    base = pops;
    repeat (20) step(1'b1, 1'b1, 1'b0, '0);
    chk("stream_rate", 32'(pops - base), 32'd10);
    step(1'b1, 1'b1, 1'b0, '0);

    // reset while a read is in flight
    chk("mid_wait", 32'(IMEM_REQ), 32'd0);
    rst_on();
    chk("arst_req", 32'(IMEM_REQ), 32'd0);
    chk("arst_addr", IMEM_ADDR, 32'd0);
    chk("arst_valid", 32'(INSTR_VALID), 32'd0);
    chk("arst_instr", INSTR, 32'd0);
    chk("arst_ipc", INSTR_PC, 32'd0);
    chk("arst_pc", PC_Current, 32'd0);
    rst_off();

    // back-pressure
    base = fires;
    repeat (8) step(1'b1, 1'b0, 1'b0, '0);
    chk("bp_fires", 32'(fires - base), 32'd2);
    chk("bp_valid", 32'(INSTR_VALID), 32'd1);
    chk("bp_head", INSTR_PC, 32'd0);
    chk("bp_req", 32'(IMEM_REQ), 32'd0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("bp_req_after", 32'(IMEM_REQ), 32'd1);
    chk("bp_addr_after", IMEM_ADDR, 32'd8);
    chk("bp_head_after", INSTR_PC, 32'd4);

    // redirect while waiting on a slow read
    rst_on();
    rst_off();
    lat_lo = 3;
    lat_hi = 3;
    base = fires;
    for (n = 0; n < 30 && fires - base < 2; n++)
      step(1'b1, 1'b1, 1'b0, '0);
    chk("t4_second_fire", 32'(fires - base), 32'd2);
    step(1'b1, 1'b1, 1'b1, 32'h100);
    chk("t4_req", 32'(IMEM_REQ), 32'd1);
    chk("t4_addr", IMEM_ADDR, 32'h100);
    for (n = 0; n < 30 && !INSTR_VALID; n++)
      step(1'b1, 1'b0, 1'b0, '0);
    chk("t4_valid", 32'(INSTR_VALID), 32'd1);
    chk("t4_head", INSTR_PC, 32'h100);

    // redirect together with a response and a pop
    rst_on();
    rst_off();
    lat_lo = 1;
    lat_hi = 1;
    base = fires;
    for (n = 0; n < 30 && fires - base < 2; n++)
      step(1'b1, 1'b0, 1'b0, '0);
    chk("t5_valid_before", 32'(INSTR_VALID), 32'd1);
    chk("t5_resp_due", 32'(mq.size() == 1 && mq[0].due <= cyc), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h200);
    chk("t5_empty", 32'(INSTR_VALID), 32'd0);
    chk("t5_req", 32'(IMEM_REQ), 32'd1);
    chk("t5_addr", IMEM_ADDR, 32'h200);
    for (n = 0; n < 30 && !INSTR_VALID; n++)
      step(1'b1, 1'b0, 1'b0, '0);
    chk("t5_head", INSTR_PC, 32'h200);

    // misaligned redirect target
    rst_on();
    rst_off();
    repeat (4) step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef PC_MISALIGN_TRAP_EN
    repeat (6) begin
      chk("t6_err", 32'(MISALIGN_ERR), 32'd1);
      chk("t6_req", 32'(IMEM_REQ), 32'd0);
      step(1'b1, 1'b1, 1'b0, '0);
    end
`else
    chk("t6_addr", IMEM_ADDR, 32'h102);
    for (n = 0; n < 30 && !INSTR_VALID; n++)
      step(1'b1, 1'b0, 1'b0, '0);
    chk("t6_head", INSTR_PC, 32'h102);
    chk("t6_data", INSTR, memf(32'h102));
`endif

    // random traffic
    rst_on();
    rst_off();
    lat_lo = 1;
    lat_hi = 4;
    base = pops;
    for (int i = 0; i < 3000; i++) begin
      bit          g, r, d;
      logic [31:0] t;
      g = ($urandom_range(99, 0) < 70);
      r = ($urandom_range(99, 0) < 60);
      d = ($urandom_range(99, 0) < 3);
      t = $urandom & 32'h0000_0FFC;
      if (!TRAP && $urandom_range(9, 0) == 0)
        t[1:0] = 2'($urandom_range(3, 0));
      step(g, r, d, t);
    end
    chk("rand_progress", 32'(pops - base > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
